// File: rtl/vision_pkg.sv
// vision_pkg: shared widths and state encoding for the vision pipeline blocks
package vision_pkg;
  localparam int MOM_W = 32;
  localparam int DIV_ITERS = 32;
  typedef enum logic [2:0] {IDLE, SNAP, CHECK, DIV_X, DIV_Y, OUT} centroid_state_t;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: 32/32 unsigned restoring divider, one quotient bit per cycle
module seq_divider
  import vision_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic [MOM_W-1:0] dividend,
  input  logic [MOM_W-1:0] divisor,
  output logic [MOM_W-1:0] quotient,
  output logic             done
);
  logic [MOM_W-1:0] rem, quo, d;
  logic [5:0] cnt;
  logic [MOM_W:0] sh;
  logic fit;
  // quotient/done are combinational so the caller can capture on the 32nd edge itself
  always_comb begin
    sh = {rem, quo[MOM_W-1]};
    fit = sh >= {1'b0, d};
    quotient = {quo[MOM_W-2:0], fit};
    done = cnt == 6'd1;
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      rem <= '0;
      quo <= '0;
      d <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= '0;
      quo <= dividend;
      d <= divisor;
      cnt <= 6'(DIV_ITERS);
    end else if (cnt != 6'd0) begin
      rem <= fit ? MOM_W'(sh - {1'b0, d}) : sh[MOM_W-1:0];
      quo <= quotient;
      cnt <= cnt - 6'd1;
    end
  end
endmodule

// File: rtl/centroid_ctrl.sv
// centroid_ctrl: per-frame moment snapshot, centroid division and result handshake
module centroid_ctrl
  import vision_pkg::*;
#(
  parameter int COORD_W = 12,
  parameter int MIN_PIX = 64,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               enable,
  input  logic               frame_start,
  input  logic [MOM_W-1:0]   m00,
  input  logic [MOM_W-1:0]   m10,
  input  logic [MOM_W-1:0]   m01,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic [MOM_W-1:0]   pix_cnt,
  output logic               target_lost,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic               timeout,
  output logic [15:0]        drop_cnt
);
  centroid_state_t state, nxt;
  logic [MOM_W-1:0] snap_m00, snap_m10, snap_m01, div_a, div_q, to_cnt;
  logic armed, fs_en, hs, lost, drop, div_start, div_done;
  function automatic logic [COORD_W-1:0] sat(input logic [MOM_W-1:0] q);
    return (q >> COORD_W) != '0 ? '1 : q[COORD_W-1:0];
  endfunction
  assign fs_en = frame_start & enable;
  assign hs = state == OUT && res_ready;
  assign lost = snap_m00 < MOM_W'(MIN_PIX);
  assign drop = fs_en && state != IDLE && !hs;
  always_ff @(posedge clk) state <= srst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = fs_en && armed ? SNAP : IDLE;
      SNAP:    nxt = CHECK;
      CHECK:   nxt = lost ? OUT : DIV_X;
      DIV_X:   nxt = div_done ? DIV_Y : DIV_X;
      DIV_Y:   nxt = div_done ? OUT : DIV_Y;
      OUT:     nxt = !res_ready ? OUT : fs_en && armed ? SNAP : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    res_valid = state == OUT;
    div_start = (state == CHECK && !lost) || (state == DIV_X && div_done);
    div_a = state == CHECK ? snap_m10 : snap_m01;
  end
  seq_divider u_div (
    .clk(clk),
    .srst(srst),
    .start(div_start),
    .dividend(div_a),
    .divisor(snap_m00),
    .quotient(div_q),
    .done(div_done)
  );
  always_ff @(posedge clk) begin
    if (srst) begin
      armed <= 1'b0;
      snap_m00 <= '0;
      snap_m10 <= '0;
      snap_m01 <= '0;
      cx <= '0;
      cy <= '0;
      pix_cnt <= '0;
      target_lost <= 1'b1;
      drop_cnt <= '0;
      to_cnt <= '0;
    end else begin
      // a frame seen while disarmed only re-arms; its moments are partial
      armed <= !enable ? 1'b0 : (fs_en && (state == IDLE || hs)) ? 1'b1 : armed;
      if (state == SNAP) begin
        snap_m00 <= m00;
        snap_m10 <= m10;
        snap_m01 <= m01;
      end
      if (state == CHECK) pix_cnt <= snap_m00;
      if (state == CHECK && lost) target_lost <= 1'b1;
      if (state == DIV_X && div_done) cx <= sat(div_q);
      if (state == DIV_Y && div_done) begin
        cy <= sat(div_q);
        target_lost <= 1'b0;
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      to_cnt <= frame_start ? '0 : to_cnt != MOM_W'(TIMEOUT_CYC) ? to_cnt + 1'b1 : to_cnt;
    end
  end
  assign timeout = to_cnt == MOM_W'(TIMEOUT_CYC);
endmodule

// File: tb/tb_centroid_ctrl.sv
// tb_centroid_ctrl: scoreboard-driven checks of centroid_ctrl timing and results
module tb_centroid_ctrl;
  localparam int CW = 12;
  localparam int MINP = 64;
  localparam int TO = 1000;
  logic clk = 1'b0;
  logic srst, enable, frame_start, res_ready;
  logic [31:0] m00, m10, m01, pix_cnt;
  logic [CW-1:0] cx, cy;
  logic target_lost, res_valid, busy, timeout;
  logic [15:0] drop_cnt;
  typedef struct {
    logic [CW-1:0] cx;
    logic [CW-1:0] cy;
    logic [31:0] pix;
    logic lost;
  } exp_t;
  exp_t sb[$];
  logic [CW-1:0] mcx = '0, mcy = '0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  centroid_ctrl #(.COORD_W(CW), .MIN_PIX(MINP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .srst(srst), .enable(enable), .frame_start(frame_start),
    .m00(m00), .m10(m10), .m01(m01), .cx(cx), .cy(cy), .pix_cnt(pix_cnt),
    .target_lost(target_lost), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .timeout(timeout), .drop_cnt(drop_cnt)
  );
  always @(negedge clk) if (!srst && res_valid && res_ready) begin
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL result_unexpected: got cx=%0d cy=%0d with no frame pending", cx, cy);
    end else begin
      e = sb.pop_front();
      if (cx !== e.cx || cy !== e.cy || pix_cnt !== e.pix || target_lost !== e.lost) begin
        errors++;
        $display("FAIL result: got cx=%0d cy=%0d pix=%0d lost=%b expected cx=%0d cy=%0d pix=%0d lost=%b",
                 cx, cy, pix_cnt, target_lost, e.cx, e.cy, e.pix, e.lost);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    m00 = a; m10 = b; m01 = c;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask
  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    exp_t e;
    longint qx, qy;
    e.pix = a;
    if (a < MINP) begin
      e.lost = 1'b1; e.cx = mcx; e.cy = mcy;
    end else begin
      qx = longint'(b) / longint'(a);
      qy = longint'(c) / longint'(a);
      if (qx > 4095) qx = 4095;
      if (qy > 4095) qy = 4095;
      e.lost = 1'b0; e.cx = qx[CW-1:0]; e.cy = qy[CW-1:0];
      mcx = e.cx; mcy = e.cy;
    end
    sb.push_back(e);
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 300) begin
      tick();
      n++;
    end
  endtask
  task automatic handshake;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask
  task automatic frame_latency(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input int lat);
    int n;
    push_exp(a, b, c);
    send(a, b, c);
    wait_valid(n);
    checks++;
    if (n !== lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges expected %0d", name, n, lat);
    end
    handshake();
  endtask
  task automatic test_reset;
    srst = 1'b1; enable = 1'b0; frame_start = 1'b0; res_ready = 1'b0;
    m00 = '0; m10 = '0; m01 = '0;
    repeat (3) tick();
    srst = 1'b0;
    checks++;
    if ({cx, cy, pix_cnt, target_lost, res_valid, busy, timeout, drop_cnt} !== {24'd0, 32'd0, 4'b1000, 16'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h",
               {cx, cy, pix_cnt, target_lost, res_valid, busy, timeout, drop_cnt}, {24'd0, 32'd0, 4'b1000, 16'd0});
    end
  endtask
  task automatic test_nominal;
    enable = 1'b1;
    send(100, 32000, 24000);
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_frame_discard: got busy=%b valid=%b expected 0 0", busy, res_valid);
    end
    frame_latency("nominal", 100, 32000, 24000, 66);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_drop: got %b expected 0", res_valid);
    end
  endtask
  task automatic test_lost;
    frame_latency("lost", 10, 5, 5, 2);
    frame_latency("lost_63", 63, 6300, 630, 2);
    frame_latency("found_64", 64, 6400, 640, 66);
  endtask
  task automatic test_saturation;
    frame_latency("sat", 64, 263000, 1000, 66);
    frame_latency("floor", 300, 1000, 299, 66);
  endtask
  task automatic test_back_to_back;
    int n;
    logic [15:0] d0;
    logic [CW-1:0] c0, c1;
    logic stable;
    d0 = drop_cnt;
    push_exp(200, 40000, 20000);
    send(200, 40000, 20000);
    repeat (10) tick();
    send(500, 1, 1);
    checks++;
    if (drop_cnt !== d0 + 16'd1) begin
      errors++;
      $display("FAIL overrun_drop: got %0d expected %0d", drop_cnt, d0 + 16'd1);
    end
    wait_valid(n);
    c0 = cx; c1 = cy; stable = 1'b1;
    repeat (50) begin
      tick();
      if (res_valid !== 1'b1 || cx !== c0 || cy !== c1 || pix_cnt !== 32'd200) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_hold: got stable=%b expected 1", stable);
    end
    push_exp(400, 8000, 4000);
    m00 = 400; m10 = 8000; m01 = 4000;
    res_ready = 1'b1; frame_start = 1'b1;
    tick();
    res_ready = 1'b0; frame_start = 1'b0;
    checks++;
    if (drop_cnt !== d0 + 16'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL handshake_frame: got drop=%0d busy=%b expected drop=%0d busy=1", drop_cnt, busy, d0 + 16'd1);
    end
    wait_valid(n);
    checks++;
    if (n !== 66) begin
      errors++;
      $display("FAIL handshake_frame_latency: got %0d edges expected 66", n);
    end
    handshake();
  endtask
  task automatic test_timeout_enable;
    int n;
    logic [15:0] d0;
    logic quiet;
    d0 = drop_cnt;
    enable = 1'b0;
    send(0, 0, 0);
    n = 0;
    while (!timeout && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n !== TO) begin
      errors++;
      $display("FAIL timeout_rise: got %0d cycles expected %0d", n, TO);
    end
    repeat (5) tick();
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b expected 1", timeout);
    end
    enable = 1'b1;
    send(100, 32000, 24000);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b expected 0", timeout);
    end
    quiet = 1'b1;
    repeat (70) begin
      tick();
      if (res_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1 || drop_cnt !== d0) begin
      errors++;
      $display("FAIL reenable_discard: got quiet=%b drop=%0d expected quiet=1 drop=%0d", quiet, drop_cnt, d0);
    end
    frame_latency("reenable", 150, 30000, 15000, 66);
  endtask
  task automatic test_reset_mid;
    logic quiet;
    send(100, 32000, 24000);
    repeat (40) tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    mcx = '0; mcy = '0;
    checks++;
    if ({cx, cy, pix_cnt, target_lost, res_valid, busy, timeout, drop_cnt} !== {24'd0, 32'd0, 4'b1000, 16'd0}) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected %h",
               {cx, cy, pix_cnt, target_lost, res_valid, busy, timeout, drop_cnt}, {24'd0, 32'd0, 4'b1000, 16'd0});
    end
    quiet = 1'b1;
    repeat (80) begin
      tick();
      if (res_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_no_result: got valid during abort window, expected none");
    end
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_lost();
    test_saturation();
    test_back_to_back();
    test_timeout_enable();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
